// File: rtl/rf_mover.sv
// rf_mover: copies a run of RF lines through the move-side port, one line per cycle
module rf_mover #(
  parameter int RF_ADDR_W = 10,
  parameter int LINE_W    = 10,
  parameter int DATA_W    = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RF_ADDR_W-1:0] src_addr,
  input  logic [RF_ADDR_W-1:0] dst_addr,
  input  logic                 src_freeze,
  input  logic                 dst_freeze,
  input  logic [LINE_W-1:0]    line_num,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [RF_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [RF_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [RF_ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic sfrz_q, sfrz_d, dfrz_q, dfrz_d, wr_en_q, wr_en_d;
  logic accept;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: an empty command skips straight to the completion pulse
  always_comb begin
    accept  = state_q == IDLE && start;
    state_d = state_q == IDLE  ? (start ? (line_num == '0 ? DONE : READ) : IDLE) :
              state_q == READ  ? (cnt_q == LINE_W'(1) ? DRAIN : READ) :
              state_q == DRAIN ? DONE : IDLE;
  end
  // datapath registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      sfrz_q  <= 1'b0;
      dfrz_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      sfrz_q  <= sfrz_d;
      dfrz_q  <= dfrz_d;
      wr_en_q <= wr_en_d;
    end
  // pointers advance after each read/write unless frozen; count tracks reads left to issue
  always_comb begin
    src_d   = accept ? src_addr : (state_q == READ && !sfrz_q) ? src_q + 1'b1 : src_q;
    dst_d   = accept ? dst_addr : (wr_en_q && !dfrz_q) ? dst_q + 1'b1 : dst_q;
    cnt_d   = accept ? line_num : state_q == READ ? cnt_q - 1'b1 : cnt_q;
    sfrz_d  = accept ? src_freeze : sfrz_q;
    dfrz_d  = accept ? dst_freeze : dfrz_q;
    wr_en_d = state_q == READ;
  end
  // outputs: write trails read by the RAM's one-cycle latency
  always_comb begin
    busy    = state_q == READ || state_q == DRAIN;
    done    = state_q == DONE;
    rd_en   = state_q == READ;
    rd_addr = src_q;
    wr_en   = wr_en_q;
    wr_addr = dst_q;
    wr_data = rd_data;
  end
endmodule

// File: tb/tb_rf_mover.sv
// tb_rf_mover: scoreboard bench for rf_mover against a read-old-data RAM model
module tb_rf_mover;
  logic clk = 1'b0;
  logic rst_n, start, src_freeze, dst_freeze, busy, done, rd_en, wr_en, init;
  logic [9:0] src_addr, dst_addr, line_num, rd_addr, wr_addr;
  logic [127:0] rd_data, wr_data;
  logic [127:0] mem [1024];
  logic [127:0] sh [1024];
  logic [9:0] exp_rd [$];
  logic [137:0] exp_wr [$];
  int compared = 0, mismatched = 0;

  rf_mover dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .src_freeze(src_freeze), .dst_freeze(dst_freeze), .line_num(line_num),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] f(input int i);
    return {32'(i * 32'h9E3779B1), 32'(~i), 32'(i * 3 + 7), 32'(i ^ 32'h5A5A)};
  endfunction

  always @(posedge clk)
    if (init) for (int i = 0; i < 1024; i++) mem[i] <= f(i);
    else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [137:0] w;
    if (rd_en) begin
      chk("rd_q_empty", 128'(exp_rd.size() == 0), 128'(0));
      if (exp_rd.size() != 0) chk("rd_addr", 128'(rd_addr), 128'(exp_rd.pop_front()));
    end
    if (wr_en) begin
      chk("wr_q_empty", 128'(exp_wr.size() == 0), 128'(0));
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(w[137:128]));
        chk("wr_data", wr_data, w[127:0]);
      end
    end
  end

  task automatic move(input logic [9:0] s, input logic [9:0] d, input logic sf, input logic df,
                      input logic [9:0] n, input int busy_at, input int rst_at);
    logic [9:0] sa [$];
    logic [9:0] da [$];
    logic [127:0] dv [$];
    int last;
    for (int i = 0; i < 1024; i++) sh[i] = mem[i];
    for (int k = 0; k < int'(n); k++) begin
      sa.push_back(s + (sf ? 10'd0 : 10'(k)));
      da.push_back(d + (df ? 10'd0 : 10'(k)));
      if (k >= 2) sh[da[k-2]] = dv[k-2];
      dv.push_back(sh[sa[k]]);
      exp_rd.push_back(sa[k]);
      exp_wr.push_back({da[k], dv[k]});
    end
    start = 1'b1; src_addr = s; dst_addr = d; src_freeze = sf; dst_freeze = df; line_num = n;
    @(negedge clk); #1; start = 1'b0;
    last = n == 0 ? 1 : int'(n) + 2;
    for (int c = 1; c <= last; c++) begin
      chk("busy", 128'(busy), 128'(n != 0 && c <= int'(n) + 1));
      chk("done", 128'(done), 128'(c == last));
      chk("rd_en", 128'(rd_en), 128'(c <= int'(n)));
      chk("wr_en", 128'(wr_en), 128'(c >= 2 && c <= int'(n) + 1));
      if (c == rst_at) begin
        rst_n = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        #1;
        chk("rst_ctrl", 128'({busy, done, rd_en, wr_en}), 128'(0));
        chk("rst_addr", 128'({rd_addr, wr_addr}), 128'(0));
        repeat (3) @(negedge clk);
        #1; rst_n = 1'b1;
        return;
      end
      if (c == busy_at) begin
        start = 1'b1; src_addr = 10'h123; dst_addr = 10'h3C0; line_num = 10'd2;
      end
      @(negedge clk); #1; start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
    src_freeze = 1'b0; dst_freeze = 1'b0; line_num = '0;
    repeat (3) @(negedge clk);
    init = 1'b0;
    chk("reset_ctrl", 128'({busy, done, rd_en, wr_en}), 128'(0));
    chk("reset_addr", 128'({rd_addr, wr_addr}), 128'(0));
    @(negedge clk); #1; rst_n = 1'b1;
    move(10'h010, 10'h200, 1'b0, 1'b0, 10'd4, 0, 0);
    move(10'h005, 10'h100, 1'b1, 1'b0, 10'd3, 0, 0);
    for (int i = 0; i < 3; i++) chk("bcast_mem", mem[10'h100 + i], mem[10'h005]);
    move(10'h3FE, 10'h3FF, 1'b0, 1'b0, 10'd3, 0, 0);
    move(10'h020, 10'h080, 1'b0, 1'b0, 10'd0, 0, 0);
    move(10'h040, 10'h300, 1'b0, 1'b0, 10'd4, 2, 0);
    move(10'h050, 10'h310, 1'b0, 1'b0, 10'd2, 0, 0);
    move(10'h060, 10'h320, 1'b0, 1'b0, 10'd8, 0, 3);
    move(10'h070, 10'h330, 1'b0, 1'b0, 10'd1, 0, 0);
    move(10'h000, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 0, 0);
    chk("max_mem", mem[10'h3FF], mem[10'h3FE]);
    repeat (4) @(negedge clk);
    chk("rd_q_left", 128'(exp_rd.size()), 128'(0));
    chk("wr_q_left", 128'(exp_wr.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
